alu_rs: RTL and testbench
=========================

# alu_rs

ALU reservation station: buffers dispatched ALU instructions until both operands are available, snoops the ALU common data bus for results, and issues one ready instruction per cycle to the ALU. It is the receiving end of the ALU CDB broadcast. Each result broadcast updates waiting operands. The finish signal, which carries the originating RS entry number, retires that entry. It sits between the dispatch/decode stage and the ALU.

## Interface
- RS_NUM_WIDTH, 3: entry index width; entry count is 2^RS_NUM_WIDTH.
- TAG_WIDTH, 5: ROB tag width; tag value 0 means "no dependency, data valid".
- DATA_WIDTH, 32: operand/result width.
- OP_WIDTH, 5: ALU opcode width.

- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous and active-low.
- flush  in  1  synchronous clear of all entries (branch mispredict).
- dispValid  in  1  dispatch request.
- dispOp  in  OP_WIDTH  opcode.
- dispTag1 / dispTag2  in  TAG_WIDTH  producer tag of operand 1/2; 0 = operand data valid.
- dispData1 / dispData2  in  DATA_WIDTH  operand value, used when tag is 0.
- dispDestTag  in  TAG_WIDTH  ROB tag of this instruction.
- rsFull  out  1  no free entry; dispatch ignored while high.
- cdbValid  in  1  result broadcast valid.
- cdbTag  in  TAG_WIDTH  tag of broadcast result.
- cdbData  in  DATA_WIDTH  broadcast result.
- cdbFinish  in  1  ALU completed the instruction held in entry cdbRSNum.
- cdbRSNum  in  RS_NUM_WIDTH  entry to retire.
- aluReady  in  1  ALU can accept an instruction this cycle.
- issueValid  out  1  one-cycle pulse; issue fields valid.
- issueOp  out  OP_WIDTH  opcode.
- issueA / issueB  out  DATA_WIDTH  operand values.
- issueDestTag  out  TAG_WIDTH  destination tag.
- issueRSNum  out  RS_NUM_WIDTH  issuing entry index, returned later on cdbRSNum.

## Operation
- Entry states: FREE -> WAIT (dispatched, not issued) -> ISSUED -> FREE.
- Dispatch: when dispValid && !rsFull && !flush, the block writes the lowest-index FREE entry at the clock edge and sets its state to WAIT. A dispatch while rsFull is high is dropped silently.
- Dispatch bypass: if cdbValid && cdbTag == dispTagN && dispTagN != 0 in the same cycle, operand N is stored with data = cdbData and tag = 0.
- Snoop: every WAIT entry whose operand tag matches cdbTag (tag != 0) while cdbValid is high captures cdbData and clears the tag to 0. Both operands can match at once.
- Ready: entry in WAIT with both tags 0.
- Issue select: lowest-index ready entry, evaluated from registered state only. Operands captured in the current cycle make the entry ready from the next cycle.
- Issue: when aluReady && a ready entry exists && !flush, the issue outputs are registered from that entry, the entry moves to ISSUED, and issueValid is high for the following cycle. Otherwise issueValid is 0 and the other issue outputs hold their previous values.
- Retire: cdbFinish moves entry cdbRSNum from ISSUED to FREE. A cdbFinish naming an entry that is not ISSUED is ignored.
- rsFull: combinational; high when no entry is FREE, computed from registered state. An entry retired in cycle N is reusable by a dispatch in cycle N+1, not N.
- flush: at the edge, all entries go FREE and issueValid goes 0. Flush overrides dispatch, issue, snoop and retire in that cycle.

## Timing
- Reset (rst low, asynchronous): all entries FREE, all stored tags/data 0, issueValid 0, issueOp/issueA/issueB/issueDestTag/issueRSNum 0, rsFull 0.
- Dispatch with both tags 0 in cycle N: the entry can issue at edge N+1, so issueValid is high in cycle N+2.
- CDB broadcast at edge N completing the last operand: the entry can issue at edge N+1.
- Throughput: at most one dispatch, one issue and one retire per cycle, all concurrent.
- Retire and a snoop of the same tag into other entries in the same cycle: both take effect.

## Test plan
- Reset then dispatch op=ADD, tag1=0, data1=5, tag2=0, data2=7, dest=3 -> issueValid pulses 2 cycles later with issueA=5, issueB=7, issueDestTag=3, issueRSNum=0.
- Dispatch tag1=4 with aluReady high; hold 3 cycles, then cdbValid with cdbTag=4, cdbData=0x10 -> no issue before the broadcast; issue follows with issueA=0x10.
- Dispatch tag2=6 in the same cycle as a CDB broadcast of tag 6 with data 0x99 (bypass) -> issueB=0x99 with no further broadcast.
- Fill all 8 entries -> rsFull=1 and a 9th dispatch is dropped. cdbFinish on entry 2 (ISSUED) -> rsFull=0 next cycle, and the next dispatch lands in entry 2.
- Two ready entries at indices 1 and 5 with aluReady low, then aluReady high -> entry 1 issues first and entry 5 issues next cycle.
- flush asserted with 4 entries in mixed states and a concurrent dispatch -> all entries FREE, issueValid=0, dispatch dropped; a later cdbFinish to any entry is ignored.

Source files
------------

// File: rtl/alu_rs.sv
// ============================================================================
// Module  : alu_rs
// Brief   : ALU reservation station with CDB snooping, dispatch bypass and
//           lowest-index issue selection.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_rs #(
  parameter int RS_NUM_WIDTH = 3,
  parameter int TAG_WIDTH    = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int OP_WIDTH     = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    dispValid,
  input  logic [OP_WIDTH-1:0]     dispOp,
  input  logic [TAG_WIDTH-1:0]    dispTag1,
  input  logic [TAG_WIDTH-1:0]    dispTag2,
  input  logic [DATA_WIDTH-1:0]   dispData1,
  input  logic [DATA_WIDTH-1:0]   dispData2,
  input  logic [TAG_WIDTH-1:0]    dispDestTag,
  output logic                    rsFull,
  input  logic                    cdbValid,
  input  logic [TAG_WIDTH-1:0]    cdbTag,
  input  logic [DATA_WIDTH-1:0]   cdbData,
  input  logic                    cdbFinish,
  input  logic [RS_NUM_WIDTH-1:0] cdbRSNum,
  input  logic                    aluReady,
  output logic                    issueValid,
  output logic [OP_WIDTH-1:0]     issueOp,
  output logic [DATA_WIDTH-1:0]   issueA,
  output logic [DATA_WIDTH-1:0]   issueB,
  output logic [TAG_WIDTH-1:0]    issueDestTag,
  output logic [RS_NUM_WIDTH-1:0] issueRSNum
);

  localparam int ENTRIES = 1 << RS_NUM_WIDTH;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ISSUED = 2'd2
  } state_e;

  state_e                  state_q [ENTRIES];
  logic [OP_WIDTH-1:0]     op_q    [ENTRIES];
  logic [TAG_WIDTH-1:0]    tag1_q  [ENTRIES];
  logic [TAG_WIDTH-1:0]    tag2_q  [ENTRIES];
  logic [DATA_WIDTH-1:0]   data1_q [ENTRIES];
  logic [DATA_WIDTH-1:0]   data2_q [ENTRIES];
  logic [TAG_WIDTH-1:0]    dest_q  [ENTRIES];

  logic [ENTRIES-1:0]      free_w;
  logic [ENTRIES-1:0]      ready_w;
  logic [RS_NUM_WIDTH-1:0] free_idx_w;
  logic [RS_NUM_WIDTH-1:0] rdy_idx_w;
  logic                    dispatch_w;
  logic                    byp1_w;
  logic                    byp2_w;

  // Descending scan leaves the lowest matching index in the select outputs.
  always_comb begin
    free_w     = '0;
    ready_w    = '0;
    free_idx_w = '0;
    rdy_idx_w  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      free_w[i]  = (state_q[i] == ST_FREE);
      ready_w[i] = (state_q[i] == ST_WAIT) && (tag1_q[i] == '0) && (tag2_q[i] == '0);
      if (free_w[i])  free_idx_w = RS_NUM_WIDTH'(i);
      if (ready_w[i]) rdy_idx_w  = RS_NUM_WIDTH'(i);
    end
  end

  assign rsFull     = ~|free_w;
  assign dispatch_w = dispValid && !rsFull;
  assign byp1_w     = cdbValid && (dispTag1 != '0) && (dispTag1 == cdbTag);
  assign byp2_w     = cdbValid && (dispTag2 != '0) && (dispTag2 == cdbTag);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        state_q[i] <= ST_FREE;
        op_q[i]    <= '0;
        tag1_q[i]  <= '0;
        tag2_q[i]  <= '0;
        data1_q[i] <= '0;
        data2_q[i] <= '0;
        dest_q[i]  <= '0;
      end
      issueValid   <= 1'b0;
      issueOp      <= '0;
      issueA       <= '0;
      issueB       <= '0;
      issueDestTag <= '0;
      issueRSNum   <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) state_q[i] <= ST_FREE;
      issueValid <= 1'b0;
    end else begin
      // Only WAIT entries snoop, so the entry being dispatched (FREE) never collides.
      for (int i = 0; i < ENTRIES; i++) begin
        if (state_q[i] == ST_WAIT && cdbValid) begin
          if (tag1_q[i] != '0 && tag1_q[i] == cdbTag) begin
            data1_q[i] <= cdbData;
            tag1_q[i]  <= '0;
          end
          if (tag2_q[i] != '0 && tag2_q[i] == cdbTag) begin
            data2_q[i] <= cdbData;
            tag2_q[i]  <= '0;
          end
        end
      end

      if (cdbFinish && state_q[cdbRSNum] == ST_ISSUED) state_q[cdbRSNum] <= ST_FREE;

      if (aluReady && |ready_w) begin
        issueValid         <= 1'b1;
        issueOp            <= op_q[rdy_idx_w];
        issueA             <= data1_q[rdy_idx_w];
        issueB             <= data2_q[rdy_idx_w];
        issueDestTag       <= dest_q[rdy_idx_w];
        issueRSNum         <= rdy_idx_w;
        state_q[rdy_idx_w] <= ST_ISSUED;
      end else begin
        issueValid <= 1'b0;
      end

      if (dispatch_w) begin
        state_q[free_idx_w] <= ST_WAIT;
        op_q[free_idx_w]    <= dispOp;
        dest_q[free_idx_w]  <= dispDestTag;
        tag1_q[free_idx_w]  <= byp1_w ? '0 : dispTag1;
        data1_q[free_idx_w] <= byp1_w ? cdbData : dispData1;
        tag2_q[free_idx_w]  <= byp2_w ? '0 : dispTag2;
        data2_q[free_idx_w] <= byp2_w ? cdbData : dispData2;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_rs.sv
// ============================================================================
// Module  : tb_alu_rs
// Brief   : Directed self-checking bench for alu_rs with a per-cycle reference
//           model and hand-computed checkpoints.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_rs;

  localparam int NE = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        dispValid = 1'b0;
  logic [4:0]  dispOp = '0;
  logic [4:0]  dispTag1 = '0;
  logic [4:0]  dispTag2 = '0;
  logic [31:0] dispData1 = '0;
  logic [31:0] dispData2 = '0;
  logic [4:0]  dispDestTag = '0;
  logic        rsFull;
  logic        cdbValid = 1'b0;
  logic [4:0]  cdbTag = '0;
  logic [31:0] cdbData = '0;
  logic        cdbFinish = 1'b0;
  logic [2:0]  cdbRSNum = '0;
  logic        aluReady = 1'b0;
  logic        issueValid;
  logic [4:0]  issueOp;
  logic [31:0] issueA;
  logic [31:0] issueB;
  logic [4:0]  issueDestTag;
  logic [2:0]  issueRSNum;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  alu_rs dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispValid(dispValid), .dispOp(dispOp), .dispTag1(dispTag1), .dispTag2(dispTag2),
    .dispData1(dispData1), .dispData2(dispData2), .dispDestTag(dispDestTag),
    .rsFull(rsFull),
    .cdbValid(cdbValid), .cdbTag(cdbTag), .cdbData(cdbData),
    .cdbFinish(cdbFinish), .cdbRSNum(cdbRSNum),
    .aluReady(aluReady),
    .issueValid(issueValid), .issueOp(issueOp), .issueA(issueA), .issueB(issueB),
    .issueDestTag(issueDestTag), .issueRSNum(issueRSNum)
  );

  // Reference model: entry status 0=free, 1=waiting, 2=issued.
  typedef struct {
    int          st;
    logic [4:0]  op, t1, t2, dest;
    logic [31:0] d1, d2;
  } ent_t;

  ent_t        m [NE];
  ent_t        n [NE];
  logic        m_iv, n_iv;
  logic [4:0]  m_op, n_op, m_dest, n_dest;
  logic [31:0] m_a, n_a, m_b, n_b;
  logic [2:0]  m_num, n_num;
  logic        m_full;
  int          mf, mr;

  always_comb begin
    n      = m;
    n_iv   = 1'b0;
    n_op   = m_op;
    n_a    = m_a;
    n_b    = m_b;
    n_dest = m_dest;
    n_num  = m_num;
    mf     = -1;
    mr     = -1;
    m_full = 1'b1;
    for (int i = NE - 1; i >= 0; i--) begin
      if (m[i].st == 0) begin mf = i; m_full = 1'b0; end
      if (m[i].st == 1 && m[i].t1 == 0 && m[i].t2 == 0) mr = i;
    end
    if (flush) begin
      for (int i = 0; i < NE; i++) n[i].st = 0;
    end else begin
      for (int i = 0; i < NE; i++) begin
        if (m[i].st == 1 && cdbValid && m[i].t1 != 0 && m[i].t1 == cdbTag) begin
          n[i].t1 = 0; n[i].d1 = cdbData;
        end
        if (m[i].st == 1 && cdbValid && m[i].t2 != 0 && m[i].t2 == cdbTag) begin
          n[i].t2 = 0; n[i].d2 = cdbData;
        end
      end
      if (cdbFinish && m[cdbRSNum].st == 2) n[cdbRSNum].st = 0;
      if (aluReady && mr >= 0) begin
        n_iv = 1'b1; n_op = m[mr].op; n_a = m[mr].d1; n_b = m[mr].d2;
        n_dest = m[mr].dest; n_num = 3'(mr); n[mr].st = 2;
      end
      if (dispValid && mf >= 0) begin
        n[mf].st = 1; n[mf].op = dispOp; n[mf].dest = dispDestTag;
        if (cdbValid && dispTag1 != 0 && dispTag1 == cdbTag) begin n[mf].t1 = 0; n[mf].d1 = cdbData; end
        else begin n[mf].t1 = dispTag1; n[mf].d1 = dispData1; end
        if (cdbValid && dispTag2 != 0 && dispTag2 == cdbTag) begin n[mf].t2 = 0; n[mf].d2 = cdbData; end
        else begin n[mf].t2 = dispTag2; n[mf].d2 = dispData2; end
      end
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NE; i++) begin
        m[i].st <= 0; m[i].op <= '0; m[i].t1 <= '0; m[i].t2 <= '0;
        m[i].dest <= '0; m[i].d1 <= '0; m[i].d2 <= '0;
      end
      m_iv <= 1'b0; m_op <= '0; m_a <= '0; m_b <= '0; m_dest <= '0; m_num <= '0;
    end else begin
      m <= n;
      m_iv <= n_iv; m_op <= n_op; m_a <= n_a; m_b <= n_b; m_dest <= n_dest; m_num <= n_num;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("model rsFull", 32'(rsFull), 32'(m_full));
      chk("model issueValid", 32'(issueValid), 32'(m_iv));
      chk("model issueOp", 32'(issueOp), 32'(m_op));
      chk("model issueA", issueA, m_a);
      chk("model issueB", issueB, m_b);
      chk("model issueDestTag", 32'(issueDestTag), 32'(m_dest));
      chk("model issueRSNum", 32'(issueRSNum), 32'(m_num));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [4:0] op, input logic [4:0] t1, input logic [31:0] d1,
                      input logic [4:0] t2, input logic [31:0] d2, input logic [4:0] dest);
    dispValid = 1'b1; dispOp = op; dispTag1 = t1; dispData1 = d1;
    dispTag2 = t2; dispData2 = d2; dispDestTag = dest;
  endtask

  task automatic expect_issue(input string nm, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] dest, input logic [2:0] num);
    chk({nm, " valid"}, 32'(issueValid), 32'd1);
    chk({nm, " A"}, issueA, a);
    chk({nm, " B"}, issueB, b);
    chk({nm, " dest"}, 32'(issueDestTag), 32'(dest));
    chk({nm, " rsnum"}, 32'(issueRSNum), 32'(num));
  endtask

  task automatic retire(input logic [2:0] num);
    cdbFinish = 1'b1; cdbRSNum = num;
    tick();
    cdbFinish = 1'b0;
  endtask

  initial begin
    #12;
    chk("reset rsFull", 32'(rsFull), 32'd0);
    chk("reset issueValid", 32'(issueValid), 32'd0);
    chk("reset issueA", issueA, 32'd0);
    chk("reset issueRSNum", 32'(issueRSNum), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Basic ADD: issues two cycles after dispatch.
    aluReady = 1'b1;
    disp(5'd1, 5'd0, 32'd5, 5'd0, 32'd7, 5'd3);
    tick();
    dispValid = 1'b0;
    chk("add not yet issued", 32'(issueValid), 32'd0);
    tick();
    expect_issue("add", 32'd5, 32'd7, 5'd3, 3'd0);
    chk("add op", 32'(issueOp), 32'd1);
    tick();
    chk("add one-cycle pulse", 32'(issueValid), 32'd0);
    retire(3'd0);

    // Operand waits for tag 4.
    disp(5'd2, 5'd4, 32'd0, 5'd0, 32'd2, 5'd8);
    tick();
    dispValid = 1'b0;
    repeat (3) begin
      tick();
      chk("wait no issue", 32'(issueValid), 32'd0);
    end
    cdbValid = 1'b1; cdbTag = 5'd4; cdbData = 32'h10;
    tick();
    cdbValid = 1'b0;
    chk("snoop not yet issued", 32'(issueValid), 32'd0);
    tick();
    expect_issue("snoop", 32'h10, 32'd2, 5'd8, 3'd0);
    retire(3'd0);

    // Dispatch bypass of tag 6.
    disp(5'd3, 5'd0, 32'd1, 5'd6, 32'd0, 5'd9);
    cdbValid = 1'b1; cdbTag = 5'd6; cdbData = 32'h99;
    tick();
    dispValid = 1'b0; cdbValid = 1'b0;
    tick();
    expect_issue("bypass", 32'd1, 32'h99, 5'd9, 3'd0);
    retire(3'd0);

    // Fill all entries, drop a ninth, reuse retired entry 2.
    for (int i = 0; i < NE; i++) begin
      disp(5'd4, 5'd0, 32'(i), 5'd0, 32'(2 * i), 5'(10 + i));
      tick();
    end
    chk("full after 8", 32'(rsFull), 32'd1);
    disp(5'd4, 5'd0, 32'hDEAD, 5'd0, 32'hBEEF, 5'd31);
    tick();
    dispValid = 1'b0;
    cdbFinish = 1'b1; cdbRSNum = 3'd2;
    chk("full during retire", 32'(rsFull), 32'd1);
    tick();
    cdbFinish = 1'b0;
    chk("not full after retire", 32'(rsFull), 32'd0);
    disp(5'd5, 5'd0, 32'h55, 5'd0, 32'h66, 5'd20);
    tick();
    dispValid = 1'b0;
    chk("full again", 32'(rsFull), 32'd1);
    tick();
    expect_issue("reuse e2", 32'h55, 32'h66, 5'd20, 3'd2);
    for (int i = 0; i < NE; i++) retire(3'(i));
    chk("empty after retire all", 32'(rsFull), 32'd0);

    // Ready entries 1 and 5 held back by aluReady.
    aluReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      disp(5'd6, (i == 1 || i == 5) ? 5'd0 : 5'd9, 32'h100 + 32'(i), 5'd0, 32'd0, 5'(i));
      tick();
    end
    dispValid = 1'b0;
    cdbFinish = 1'b1; cdbRSNum = 3'd0;
    tick();
    cdbFinish = 1'b0;
    chk("held no issue", 32'(issueValid), 32'd0);
    aluReady = 1'b1;
    tick();
    expect_issue("prio e1", 32'h101, 32'd0, 5'd1, 3'd1);
    tick();
    expect_issue("prio e5", 32'h105, 32'd0, 5'd5, 3'd5);

    // Flush with concurrent dispatch.
    flush = 1'b1;
    disp(5'd7, 5'd0, 32'hAA, 5'd0, 32'hBB, 5'd7);
    tick();
    flush = 1'b0; dispValid = 1'b0;
    chk("flush issueValid", 32'(issueValid), 32'd0);
    chk("flush rsFull", 32'(rsFull), 32'd0);
    tick();
    chk("flush dispatch dropped", 32'(issueValid), 32'd0);
    cdbFinish = 1'b1; cdbRSNum = 3'd1;
    cdbValid = 1'b1; cdbTag = 5'd9; cdbData = 32'h77;
    tick();
    cdbFinish = 1'b0; cdbValid = 1'b0;
    tick();
    chk("post flush quiet", 32'(issueValid), 32'd0);
    disp(5'd8, 5'd0, 32'd3, 5'd0, 32'd4, 5'd11);
    tick();
    dispValid = 1'b0;
    tick();
    expect_issue("post flush e0", 32'd3, 32'd4, 5'd11, 3'd0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
